// File: rtl/nor_bist_pkg.sv
// Shared definitions for the NOR-gate built-in self-test controller.
//   state_e    : controller FSM states
//   VEC_W      : width of an {a,b} test vector
//   ERR_W      : width of the saturating mismatch counter
//   ERR_MAX    : saturation value of the mismatch counter
//   LOOP_W     : width of the completed-loop counter (LOOPS <= 15)
//   nor_expect : fault-free response of a 2-input NOR for a vector
package nor_bist_pkg;

  localparam int VEC_W   = 2;
  localparam int ERR_W   = 4;
  localparam int ERR_MAX = 15;
  localparam int LOOP_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    CHECK,
    DONE
  } state_e;

  function automatic logic nor_expect(input logic [VEC_W-1:0] vec);
    return ~(vec[1] | vec[0]);
  endfunction

endpackage

// File: rtl/nor_bist_ctrl_settle_timer.sv
// Settle timer: down-counter that paces the wait between applying a vector
// and sampling the gate output.
//   clk       : clock
//   rst_n     : asynchronous active-low reset
//   load_i    : load the counter with CYCLES
//   en_i      : decrement while high
//   expired_o : high during the last settle cycle
module settle_timer #(
  parameter int unsigned CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CNT_W'(CYCLES);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Loaded with CYCLES, so the count reads 1 on the CYCLES-th settle cycle.
  assign expired_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/nor_bist_ctrl.sv
// BIST controller for an external 2-input NOR gate. Walks the vectors
// {a,b} = 00,01,10,11 for LOOPS passes, waits SETTLE_CYCLES after each
// vector is applied, then compares y_in with the ideal NOR response.
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   start      : begin a run (honoured only in IDLE)
//   abort      : cancel a run in progress
//   y_in       : output of the gate under test
//   drv_a/b    : registered drives to the gate inputs
//   busy       : high whenever not IDLE
//   done       : one-cycle pulse on normal completion
//   pass       : last completed run had no mismatches
//   err_count  : saturating mismatch count
//   fail_valid : one-cycle pulse per mismatch
//   fail_vec   : vector of the most recent mismatch
module nor_bist_ctrl
  import nor_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned LOOPS         = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             y_in,
  output logic             drv_a,
  output logic             drv_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [VEC_W-1:0] fail_vec
);

  state_e            state_q;
  logic [VEC_W-1:0]  vec_q;
  logic [LOOP_W-1:0] loop_q;
  logic [ERR_W-1:0]  err_q;
  logic [VEC_W-1:0]  fail_vec_q;
  logic              fail_valid_q;
  logic              pass_q;
  logic              drv_a_q;
  logic              drv_b_q;

  logic              settle_done;
  logic              mismatch_d;
  logic [ERR_W-1:0]  err_d;
  logic [VEC_W-1:0]  vec_d;
  logic              last_loop_d;
  logic              in_run;

  settle_timer #(
    .CYCLES (SETTLE_CYCLES)
  ) u_settle (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (state_q == APPLY),
    .en_i      (state_q == SETTLE),
    .expired_o (settle_done)
  );

  always_comb begin
    mismatch_d  = (y_in != nor_expect(vec_q));
    err_d       = (err_q == ERR_W'(ERR_MAX)) ? err_q : err_q + 1'b1;
    vec_d       = vec_q + 1'b1;
    // loop_q counts completed passes; this pass is the last one when
    // finishing it reaches LOOPS.
    last_loop_d = ({1'b0, loop_q} + 5'd1) >= 5'(LOOPS);
    in_run      = (state_q == APPLY) || (state_q == SETTLE) || (state_q == CHECK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      loop_q       <= '0;
      err_q        <= '0;
      fail_vec_q   <= '0;
      fail_valid_q <= 1'b0;
      pass_q       <= 1'b0;
      drv_a_q      <= 1'b0;
      drv_b_q      <= 1'b0;
    end else begin
      fail_valid_q <= 1'b0;
      if (abort && in_run) begin
        // Any mismatch seen in CHECK on this edge is dropped; err_count holds.
        state_q <= IDLE;
        pass_q  <= 1'b0;
        drv_a_q <= 1'b0;
        drv_b_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              state_q    <= APPLY;
              vec_q      <= '0;
              loop_q     <= '0;
              err_q      <= '0;
              fail_vec_q <= '0;
              pass_q     <= 1'b0;
              drv_a_q    <= 1'b0;
              drv_b_q    <= 1'b0;
            end
          end
          APPLY: state_q <= SETTLE;
          SETTLE: begin
            if (settle_done) state_q <= CHECK;
          end
          CHECK: begin
            if (mismatch_d) begin
              fail_valid_q <= 1'b1;
              fail_vec_q   <= vec_q;
              err_q        <= err_d;
            end
            if (vec_q == 2'b11) begin
              if (last_loop_d) begin
                state_q <= DONE;
                pass_q  <= !mismatch_d && (err_q == '0);
                drv_a_q <= 1'b0;
                drv_b_q <= 1'b0;
              end else begin
                state_q <= APPLY;
                loop_q  <= loop_q + 1'b1;
                vec_q   <= '0;
                drv_a_q <= 1'b0;
                drv_b_q <= 1'b0;
              end
            end else begin
              state_q <= APPLY;
              vec_q   <= vec_d;
              drv_a_q <= vec_d[1];
              drv_b_q <= vec_d[0];
            end
          end
          DONE: state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign drv_a      = drv_a_q;
  assign drv_b      = drv_b_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_nor_bist_ctrl.sv
// Self-checking bench for nor_bist_ctrl. The gate under test is a 4-entry
// truth table indexed by {a,b}; a reference model enumerates the test
// vectors and queues the expected fail/done events, which a negedge
// monitor matches against the DUT outputs.
module tb_nor_bist_ctrl;

  localparam int TB_S  = 3;
  localparam int TB_L  = 4;
  localparam int NVEC  = 4 * TB_L;
  localparam int RUN   = NVEC * (TB_S + 2);

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       y_in;
  logic       drv_a;
  logic       drv_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic       fail_valid;
  logic [1:0] fail_vec;
  logic [3:0] tt_q;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int kind;  // 0 = fail_valid event, 1 = done event
    int cyc;
    int vec;
    int err;
    int pass;
  } ev_t;

  ev_t q[$];

  nor_bist_ctrl #(
    .SETTLE_CYCLES (TB_S),
    .LOOPS         (TB_L)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .y_in       (y_in),
    .drv_a      (drv_a),
    .drv_b      (drv_b),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .fail_valid (fail_valid),
    .fail_vec   (fail_vec)
  );

  // Gate under test: truth table indexed by {a,b}; 4'b0001 is a good NOR.
  assign y_in = tt_q[{drv_a, drv_b}];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every fail_valid / done pulse must match the next queued event.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      if (fail_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_fail_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("fv_kind", 0, e.kind);
          chk("fv_cycle", cyc, e.cyc);
          chk("fv_vec", int'(fail_vec), e.vec);
          chk("fv_err", int'(err_count), e.err);
          $display("txn fail_valid cyc=%0d vec=%0d err=%0d", cyc, fail_vec, err_count);
        end
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("done_kind", 1, e.kind);
          chk("done_cycle", cyc, e.cyc);
          chk("done_pass", int'(pass), e.pass);
          chk("done_err", int'(err_count), e.err);
          $display("txn done cyc=%0d pass=%0d err=%0d", cyc, pass, err_count);
        end
      end
    end
  end

  // Reference model: walk the vector list, queue each mismatch visible by
  // relative edge 'limit', optionally followed by the completion event.
  task automatic model_push(input logic [3:0] tt, input int e0, input int limit,
                            input bit with_done, output int err_lim, output int pass_f);
    int err = 0;
    err_lim = 0;
    for (int i = 0; i < NVEC; i++) begin
      int v = i % 4;
      int ideal = (v == 0) ? 1 : 0;
      int edge_n = (i + 1) * (TB_S + 2);
      if (int'(tt[v]) != ideal) begin
        err = (err < 15) ? err + 1 : 15;
        if (edge_n <= limit) begin
          q.push_back('{kind: 0, cyc: e0 + edge_n, vec: v, err: err, pass: 0});
          err_lim = err;
        end
      end
    end
    pass_f = (err == 0) ? 1 : 0;
    if (with_done) begin
      q.push_back('{kind: 1, cyc: e0 + RUN, vec: 0, err: err, pass: pass_f});
      err_lim = err;
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_start(output int e0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0 = cyc;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_err"}, int'(err_count), 0);
    chk({tag, "_fail_valid"}, int'(fail_valid), 0);
    chk({tag, "_fail_vec"}, int'(fail_vec), 0);
    chk({tag, "_drv"}, int'({drv_a, drv_b}), 0);
  endtask

  task automatic run_full(input logic [3:0] tt, input int rp_vec);
    int e0, err_exp, pass_exp;
    tt_q = tt;
    do_start(e0);
    model_push(tt, e0, RUN, 1'b1, err_exp, pass_exp);
    $display("txn run_full tt=%b start_edge=%0d exp_err=%0d exp_pass=%0d", tt, e0, err_exp, pass_exp);
    for (int i = 0; i < NVEC; i++) begin
      wait_to(e0 + i * (TB_S + 2) + 1);
      chk("run_drv_vec", int'({drv_a, drv_b}), i % 4);
      chk("run_busy", int'(busy), 1);
      if (i == rp_vec) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    wait_to(e0 + RUN);
    start = 1'b1;  // sampled while in DONE, must be ignored
    @(negedge clk);
    start = 1'b0;
    chk("post_done_busy", int'(busy), 0);
    chk("post_done_drv", int'({drv_a, drv_b}), 0);
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_pass_hold", int'(pass), pass_exp);
    chk("idle_err_hold", int'(err_count), err_exp);
    #1;
    chk("run_queue_drained", q.size(), 0);
    q.delete();
  endtask

  task automatic run_abort(input logic [3:0] tt, input int a_edge, input int p_edge);
    int e0, err_exp, pass_f;
    tt_q = tt;
    do_start(e0);
    model_push(tt, e0, a_edge - 1, 1'b0, err_exp, pass_f);
    $display("txn run_abort tt=%b start_edge=%0d abort_edge=+%0d restart_edge=+%0d exp_err=%0d",
             tt, e0, a_edge, p_edge, err_exp);
    if (p_edge > 0) begin
      wait_to(e0 + p_edge - 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_to(e0 + a_edge - 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_pass", int'(pass), 0);
    chk("abort_drv", int'({drv_a, drv_b}), 0);
    chk("abort_err", int'(err_count), err_exp);
    repeat (RUN) @(negedge clk);
    chk("abort_stays_idle", int'(busy), 0);
    chk("abort_err_hold", int'(err_count), err_exp);
    #1;
    chk("abort_queue_drained", q.size(), 0);
    q.delete();
  endtask

  task automatic run_reset(input logic [3:0] tt, input int r_edge);
    int e0, err_exp, pass_f;
    tt_q = tt;
    do_start(e0);
    model_push(tt, e0, r_edge, 1'b0, err_exp, pass_f);
    $display("txn run_reset tt=%b start_edge=%0d reset_after=+%0d exp_err_before=%0d",
             tt, e0, r_edge, err_exp);
    wait_to(e0 + r_edge);
    chk("pre_reset_err", int'(err_count), err_exp);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrun_reset");
    chk("reset_queue_drained", q.size(), 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int a_edge, p_edge;
    logic [3:0] r;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    tt_q  = 4'b0001;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;

    run_full(4'b0001, -1);   // good gate
    run_full(4'b0000, -1);   // stuck-at-0
    run_full(4'b1111, -1);   // stuck-at-1
    run_full(4'b1110, -1);   // inverted: 16 mismatches, saturates at 15
    run_abort(4'b1111, 10, 5);
    run_full(4'b0001, 2);
    run_reset(4'b1111, 2 * (TB_S + 2) + 2);  // during SETTLE of vector 10
    run_full(4'b0001, -1);

    for (int k = 0; k < 6; k++) begin
      r = 4'($urandom);
      run_full(r, int'($urandom_range(0, NVEC - 1)));
    end
    for (int k = 0; k < 4; k++) begin
      r = 4'($urandom);
      a_edge = int'($urandom_range(1, RUN));
      p_edge = (a_edge > 1) ? int'($urandom_range(1, a_edge - 1)) : 0;
      run_abort(r, a_edge, p_edge);
    end
    for (int k = 0; k < 3; k++) begin
      r = 4'($urandom);
      run_reset(r, int'($urandom_range(1, RUN)));
      run_full(4'($urandom), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nor_bist_ctrl.md
NOR_BIST_CTRL -- requirements
Module: nor_bist_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, meaning cycles waited after each vector is applied before y_in is sampled; legal range 1..15.
REQ-002 Parameter LOOPS, default 1, meaning number of complete passes over the 4-vector set; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a test run; sampled only in IDLE.
REQ-006 abort  input  1  synchronous abort of a run in progress.
REQ-007 y_in  input  1  output of the external 2-input NOR gate under test.
REQ-008 drv_a  output  1  registered drive to gate input a.
REQ-009 drv_b  output  1  registered drive to gate input b.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse on normal completion.
REQ-012 pass  output  1  result of the last completed run; high iff err_count==0.
REQ-013 err_count  output  4  saturating mismatch count for the current or last run.
REQ-014 fail_valid  output  1  one-cycle pulse per detected mismatch.
REQ-015 fail_vec  output  2  {a,b} vector of the most recent mismatch.

Function
REQ-016 The FSM SHALL have states IDLE, APPLY, SETTLE, CHECK, DONE.
REQ-017 IDLE->APPLY on start==1; on this edge err_count, fail_vec, pass and the vector and loop counters are cleared.
REQ-018 Vector order per loop SHALL be {a,b} = 00, 01, 10, 11; drv_a/drv_b update on entry to APPLY and hold through SETTLE and CHECK.
REQ-019 APPLY lasts 1 cycle, SETTLE lasts exactly SETTLE_CYCLES cycles, CHECK lasts 1 cycle, so each vector costs SETTLE_CYCLES+2 cycles.
REQ-020 In CHECK, y_in SHALL be compared with expected = ~(drv_a|drv_b); on mismatch, fail_valid pulses in the following cycle, fail_vec loads the vector and err_count increments, saturating at 15.
REQ-021 CHECK on vector 11 SHALL go to APPLY(00) if completed loops < LOOPS, else to DONE; all other CHECKs go to APPLY with the next vector.
REQ-022 done SHALL be high for exactly the cycle in DONE, beginning 4*LOOPS*(SETTLE_CYCLES+2) edges after the edge that sampled start (16 with defaults); pass updates on entry to DONE; DONE->IDLE unconditionally.
REQ-023 start while busy SHALL be ignored; start in DONE is ignored.
REQ-024 abort==1 in APPLY, SETTLE or CHECK SHALL force IDLE next edge, with pass=0, no done pulse, drv_a=drv_b=0; err_count holds; a CHECK mismatch on the aborting edge is discarded.
REQ-025 In IDLE, drv_a=drv_b=0 (gate output expected high).
REQ-026 pass and err_count SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE and set drv_a=0, drv_b=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=00, and clear all counters, including mid-run.
REQ-028 After rst_n rises, the first accepted start SHALL behave identically to a start from power-up.

Structure
REQ-029 Shared package nor_bist_pkg SHALL hold the state enum, VEC_W=2, ERR_W=4 and ERR_MAX=15.
REQ-030 The SETTLE counter SHALL be a sub-module settle_timer (load, count-down, expire flag) of width clog2(SETTLE_CYCLES+1).
REQ-031 The gate under test is external; a bench wrapper connects drv_a/drv_b/y_in to the switch-level nor_gate.

Verification
REQ-032 Good gate, defaults, start pulse -> done at edge 16, pass=1, err_count=0, no fail_valid.
REQ-033 y_in stuck-at-0 -> one fail_valid, fail_vec=00, err_count=1, pass=0.
REQ-034 y_in stuck-at-1 -> fail_valid for vectors 01, 10, 11; err_count=3, final fail_vec=11, pass=0.
REQ-035 LOOPS=8, y_in stuck-at-1 -> 24 mismatches; err_count saturates at 15; done at edge 128.
REQ-036 rst_n low during SETTLE of vector 10 -> all outputs at reset values immediately; a new start gives a clean 16-cycle run.
REQ-037 start re-pulsed at edge 5, abort at edge 9 -> start ignored, IDLE at edge 10, no done, pass=0, drv_a=drv_b=0.
